// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG pixel writer: FSM encoding, FIFO entry width
// and the frame-buffer pixel packing.
package aq_djpeg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pix_state_e;

    // FIFO entry layout: {addr[31:0], data[31:0], last}
    localparam int ENTRY_W = 65;

    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'd0, rgb};
    endfunction

endpackage

// File: rtl/aq_djpeg_pixel_writer_if.sv
// Write-command stream from the pixel writer to the memory master.
interface aq_djpeg_pixel_writer_if;
    // A command transfers on a clock edge where WR_VALID && WR_READY are both high.
    // Once WR_VALID rises the master keeps it high and holds WR_ADDR/WR_DATA/WR_LAST
    // steady until that transfer; WR_READY may depend on WR_VALID.
    logic        WR_VALID;
    logic        WR_READY;
    logic [31:0] WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_LAST;

    modport master (output WR_VALID, output WR_ADDR, output WR_DATA, output WR_LAST,
                    input  WR_READY);
    modport slave  (input  WR_VALID, input  WR_ADDR, input  WR_DATA, input  WR_LAST,
                    output WR_READY);
endinterface

// File: rtl/aq_djpeg_sync_fifo.sv
// Synchronous show-ahead FIFO: head is the oldest entry whenever empty is low.
module aq_djpeg_sync_fifo #(
    parameter int AW = 6,
    parameter int DW = 65
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = level[AW];

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aq_djpeg_pixel_writer.sv
// Turns the decoder's unstallable pixel strobe into addressed frame-buffer write commands.
// Optional statistics counters (DROP_CNT, PIX_CNT) are built when AQ_DJPEG_PIXWR_STAT_EN is defined.
module aq_djpeg_pixel_writer
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_AW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PIX_VALID,
    input  logic [15:0]          PIX_X,
    input  logic [15:0]          PIX_Y,
    input  logic [15:0]          PIX_WIDTH,
    input  logic [15:0]          PIX_HEIGHT,
    input  logic [23:0]          PIX_RGB,
    input  logic                 ENABLE,
    input  logic [31:0]          BASE_ADDR,
    input  logic [15:0]          STRIDE,
    input  logic                 CLR_OVF,
    aq_djpeg_pixel_writer_if.master wr,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW,
    output logic [FIFO_AW:0]     LEVEL,
`ifdef AQ_DJPEG_PIXWR_STAT_EN
    output logic [15:0]          DROP_CNT,
    output logic [31:0]          PIX_CNT,
`endif
    output pix_state_e           fsm_state
);
    pix_state_e          state;
    pix_state_e          next_state;
    logic                accept;
    logic                drop_in;
    logic                pipe_idle;

    logic                s1_valid;
    logic [31:0]         s1_prod;
    logic [15:0]         s1_x;
    logic [23:0]         s1_rgb;
    logic                s1_last;

    logic                s2_valid;
    logic [31:0]         s2_addr;
    logic [31:0]         s2_data;
    logic                s2_last;

    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                drop_s2;

    // Stage 1: row offset multiply and frame-end detection.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= accept;
        s1_prod <= 32'(PIX_Y) * 32'(STRIDE);
        s1_x    <= PIX_X;
        s1_rgb  <= PIX_RGB;
        s1_last <= (PIX_WIDTH != 16'd0) && (PIX_HEIGHT != 16'd0) &&
                   (PIX_X == PIX_WIDTH - 16'd1) && (PIX_Y == PIX_HEIGHT - 16'd1);
    end

    // Stage 2: final byte address, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
        s2_addr <= BASE_ADDR + s1_prod + {14'd0, s1_x, 2'b00};
        s2_data <= pack_pixel(s1_rgb);
        s2_last <= s1_last;
    end

    assign pop     = wr.WR_VALID && wr.WR_READY;
    assign drop_s2 = s2_valid && fifo_full && !pop;

    aq_djpeg_sync_fifo #(.AW(FIFO_AW), .DW(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid),
        .push_data ({s2_addr, s2_data, s2_last}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (LEVEL)
    );

    // Zero the command fields while empty so stale memory never shows on the bus.
    assign wr.WR_VALID = !fifo_empty;
    assign wr.WR_ADDR  = fifo_empty ? 32'd0 : head[64:33];
    assign wr.WR_DATA  = fifo_empty ? 32'd0 : head[32:1];
    assign wr.WR_LAST  = !fifo_empty && head[0];

    assign pipe_idle = fifo_empty && !s1_valid && !s2_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (ENABLE) next_state = ST_RUN;
            ST_RUN:   if (s2_valid && s2_last) next_state = ST_DRAIN;
            ST_DRAIN: if (pipe_idle) next_state = ENABLE ? ST_RUN : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        drop_in    = 1'b0;
        FRAME_DONE = 1'b0;
        case (state)
            ST_RUN:   accept = PIX_VALID;
            ST_DRAIN: begin
                drop_in    = PIX_VALID;
                FRAME_DONE = pipe_idle;
            end
            default: ;
        endcase
    end

    assign fsm_state = state;

    // A drop in the same cycle as CLR_OVF leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)                      OVERFLOW <= 1'b0;
        else if (drop_in || drop_s2)  OVERFLOW <= 1'b1;
        else if (CLR_OVF)             OVERFLOW <= 1'b0;
    end

`ifdef AQ_DJPEG_PIXWR_STAT_EN
    logic [1:0]  drop_n;
    logic [15:0] drop_base;

    assign drop_n    = {1'b0, drop_in} + {1'b0, drop_s2};
    assign drop_base = CLR_OVF ? 16'd0 : DROP_CNT;

    always_ff @(posedge clk) begin
        if (rst)
            DROP_CNT <= 16'd0;
        else if (drop_base > 16'hFFFF - 16'(drop_n))
            DROP_CNT <= 16'hFFFF;
        else
            DROP_CNT <= drop_base + 16'(drop_n);
    end

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && next_state == ST_RUN))
            PIX_CNT <= 32'd0;
        else if (s2_valid && !drop_s2)
            PIX_CNT <= PIX_CNT + 32'd1;
    end
`endif

endmodule
